// File: rtl/interrupt_controller_if.sv
// Signal bundle between the processor-side request logic and the interrupt controller.
// master drives requests and handshakes; slave is the controller itself.
interface interrupt_controller_if #(
    parameter int PEND_W = 2
);
    logic              irq_in;
    logic              irq_enable;
    logic              stall;
    logic              rti_done;
    logic              interrupt;
    logic              in_service;
    logic [PEND_W-1:0] pending_count;
    logic              irq_lost;
    logic [1:0]        state;

    modport master (
        output irq_in, irq_enable, stall, rti_done,
        input  interrupt, in_service, pending_count, irq_lost, state
    );

    modport slave (
        input  irq_in, irq_enable, stall, rti_done,
        output interrupt, in_service, pending_count, irq_lost, state
    );
endinterface

// File: rtl/interrupt_controller.sv
// Synchronises an external request line, counts request edges and issues one
// single-cycle interrupt per request, holding further requests off until RTI retires.
module interrupt_controller #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF     = 4,
    parameter int PEND_W      = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    interrupt_controller_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_FIRE    = 2'b01,
        S_SERVICE = 2'b10,
        S_HOLDOFF = 2'b11
    } state_t;

    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = (HOLDOFF > 0) ? HW'(HOLDOFF - 1) : '0;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_rise;
    logic [PEND_W-1:0]      r_pending;
    logic [PEND_W-1:0]      w_pending_next;
    logic                   r_lost;
    logic                   w_lost_next;
    logic [HW-1:0]          r_hold;
    logic [HW-1:0]          w_hold_next;
    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_fire;
    logic                   r_interrupt;
    logic                   r_in_service;

    // SYNC_STAGES must be at least 2 for metastability protection on irq_in.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic w_stage_in;
            if (gi == 0) begin : g_first
                assign w_stage_in = bus.irq_in;
            end else begin : g_rest
                assign w_stage_in = r_sync[gi-1];
            end
            always_ff @(posedge clk) begin
                if (!reset) r_sync[gi] <= 1'b0;
                else        r_sync[gi] <= w_stage_in;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) r_prev <= 1'b0;
        else        r_prev <= r_sync[SYNC_STAGES-1];
    end

    assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign w_fire = (r_state == S_IDLE) && (r_pending != '0) && bus.irq_enable && !bus.stall;

    // A simultaneous rise and delivery cancel out; a rise into a full counter is lost.
    always_comb begin
        w_pending_next = r_pending;
        w_lost_next    = r_lost;
        if (w_rise && !w_fire) begin
            if (&r_pending) w_lost_next    = 1'b1;
            else            w_pending_next = r_pending + 1'b1;
        end else if (w_fire && !w_rise) begin
            w_pending_next = r_pending - 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold;
        case (r_state)
            S_IDLE: begin
                if (w_fire) w_state_next = S_FIRE;
            end
            S_FIRE: begin
                w_state_next = S_SERVICE;
            end
            S_SERVICE: begin
                if (bus.rti_done) begin
                    if (HOLDOFF == 0) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_HOLDOFF;
                        w_hold_next  = HOLD_LOAD;
                    end
                end
            end
            S_HOLDOFF: begin
                if (r_hold == '0) w_state_next = S_IDLE;
                else              w_hold_next  = r_hold - 1'b1;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_hold       <= '0;
            r_pending    <= '0;
            r_lost       <= 1'b0;
            r_interrupt  <= 1'b0;
            r_in_service <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_hold       <= w_hold_next;
            r_pending    <= w_pending_next;
            r_lost       <= w_lost_next;
            r_interrupt  <= (w_state_next == S_FIRE);
            r_in_service <= (w_state_next == S_FIRE) || (w_state_next == S_SERVICE);
        end
    end

    assign bus.interrupt     = r_interrupt;
    assign bus.in_service    = r_in_service;
    assign bus.pending_count = r_pending;
    assign bus.irq_lost      = r_lost;
    assign bus.state         = r_state;
endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: vector table, directed corner sequences and
// randomized traffic compared against a behavioural model.
module tb_interrupt_controller;
    localparam int S    = 2;
    localparam int H    = 4;
    localparam int PW   = 2;
    localparam int PMAX = (1 << PW) - 1;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    interrupt_controller_if #(.PEND_W(PW)) bus ();

    interrupt_controller #(
        .SYNC_STAGES (S),
        .HOLDOFF     (H),
        .PEND_W      (PW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: irq history, a request count and the service phase.
    bit [S:0] m_hist;
    int       m_pend;
    bit       m_lost;
    bit       m_fire;
    bit       m_serv;
    int       m_hold;

    always @(posedge clk) begin : ref_model
        bit rise_v;
        bit fire_v;
        if (!reset) begin
            m_hist <= '0;
            m_pend <= 0;
            m_lost <= 1'b0;
            m_fire <= 1'b0;
            m_serv <= 1'b0;
            m_hold <= 0;
        end else begin
            rise_v = m_hist[S-1] && !m_hist[S];
            fire_v = !m_fire && !m_serv && (m_hold == 0) && (m_pend > 0)
                     && bus.irq_enable && !bus.stall;
            if (rise_v && !fire_v) begin
                if (m_pend == PMAX) m_lost <= 1'b1;
                else                m_pend <= m_pend + 1;
            end else if (fire_v && !rise_v) begin
                m_pend <= m_pend - 1;
            end
            if (m_fire) begin
                m_fire <= 1'b0;
                m_serv <= 1'b1;
            end else if (m_serv) begin
                if (bus.rti_done) begin
                    m_serv <= 1'b0;
                    m_hold <= H;
                end
            end else if (m_hold > 0) begin
                m_hold <= m_hold - 1;
            end else if (fire_v) begin
                m_fire <= 1'b1;
            end
            m_hist <= {m_hist[S-1:0], bus.irq_in};
        end
    end

    function automatic logic [6:0] model_out();
        logic [1:0] st;
        st = m_fire ? 2'd1 : (m_serv ? 2'd2 : ((m_hold > 0) ? 2'd3 : 2'd0));
        return {m_fire, m_fire | m_serv, 2'(m_pend), m_lost, st};
    endfunction

    function automatic logic [6:0] dut_out();
        return {bus.interrupt, bus.in_service, bus.pending_count, bus.irq_lost, bus.state};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic finish_service();
        bus.rti_done = 1'b1;
        tick();
        bus.rti_done = 1'b0;
        chk("holdoff_entry_state", int'(bus.state), 3);
        repeat (H) tick();
        chk("holdoff_exit_state", int'(bus.state), 0);
    endtask

    typedef struct {
        bit rst_n;
        bit irq;
        bit en;
        bit stl;
        bit rti;
        bit e_int;
        bit e_isv;
        int e_pend;
        bit e_lost;
        int e_state;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int pulses;
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        bus.irq_in = 1'b0;
        bus.irq_enable = 1'b1;
        bus.stall = 1'b0;
        bus.rti_done = 1'b0;

        // Single request: rise sampled at row 2, fire after row 5, RTI at row 7.
        tbl[0]  = '{0, 0, 1, 0, 0,  0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 0, 0,  0, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 1, 0, 0,  0, 0, 0, 0, 0};
        tbl[3]  = '{1, 1, 1, 0, 0,  0, 0, 0, 0, 0};
        tbl[4]  = '{1, 1, 1, 0, 0,  0, 0, 1, 0, 0};
        tbl[5]  = '{1, 1, 1, 0, 0,  1, 1, 0, 0, 1};
        tbl[6]  = '{1, 1, 1, 0, 0,  0, 1, 0, 0, 2};
        tbl[7]  = '{1, 1, 1, 0, 1,  0, 0, 0, 0, 3};
        tbl[8]  = '{1, 1, 1, 0, 0,  0, 0, 0, 0, 3};
        tbl[9]  = '{1, 1, 1, 0, 0,  0, 0, 0, 0, 3};
        tbl[10] = '{1, 1, 1, 0, 0,  0, 0, 0, 0, 3};
        tbl[11] = '{1, 1, 1, 0, 0,  0, 0, 0, 0, 0};
        tbl[12] = '{1, 1, 1, 0, 1,  0, 0, 0, 0, 0};
        tbl[13] = '{1, 0, 1, 0, 0,  0, 0, 0, 0, 0};

        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            logic [6:0] exp_v;
            reset          = tbl[i].rst_n;
            bus.irq_in     = tbl[i].irq;
            bus.irq_enable = tbl[i].en;
            bus.stall      = tbl[i].stl;
            bus.rti_done   = tbl[i].rti;
            tick();
            exp_v = {tbl[i].e_int, tbl[i].e_isv, 2'(tbl[i].e_pend), tbl[i].e_lost, 2'(tbl[i].e_state)};
            chk($sformatf("tbl[%0d]", i), int'(dut_out()), int'(exp_v));
        end
        bus.rti_done = 1'b0;

        // Reset held with irq_in high, then the level counts as one request.
        reset = 1'b0;
        bus.irq_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("reset_hold[%0d]", i), int'(dut_out()), 0);
        end
        reset = 1'b1;
        tick();
        chk("rel_r1_int", int'(bus.interrupt), 0);
        tick();
        chk("rel_r2_int", int'(bus.interrupt), 0);
        tick();
        chk("rel_r3_int", int'(bus.interrupt), 0);
        chk("rel_r3_pend", int'(bus.pending_count), 1);
        tick();
        chk("rel_r4_int", int'(bus.interrupt), 1);
        chk("rel_r4_pend", int'(bus.pending_count), 0);
        tick();
        chk("rel_r5_int", int'(bus.interrupt), 0);
        chk("rel_r5_state", int'(bus.state), 2);

        // Burst of four rises during SERVICE saturates the counter.
        bus.irq_in = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            bus.irq_in = (i % 2 == 0);
            tick();
        end
        bus.irq_in = 1'b0;
        repeat (3) tick();
        chk("burst_pend", int'(bus.pending_count), 3);
        chk("burst_lost", int'(bus.irq_lost), 1);
        chk("burst_state", int'(bus.state), 2);
        bus.rti_done = 1'b1;
        tick();
        bus.rti_done = 1'b0;
        chk("burst_rti_state", int'(bus.state), 3);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            pulses += int'(bus.interrupt);
        end
        chk("burst_holdoff_pulses", pulses, 0);
        tick();
        chk("burst_refire_state", int'(bus.state), 1);
        chk("burst_refire_pend", int'(bus.pending_count), 2);
        tick();
        chk("burst_service_state", int'(bus.state), 2);

        // Reset during SERVICE with two requests pending drops everything.
        reset = 1'b0;
        tick();
        chk("rst_svc_state", int'(bus.state), 0);
        chk("rst_svc_pend", int'(bus.pending_count), 0);
        chk("rst_svc_isv", int'(bus.in_service), 0);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            pulses += int'(bus.interrupt);
        end
        chk("rst_svc_no_pulse", pulses, 0);

        // Stall, then disable, hold a pending request off.
        bus.stall = 1'b1;
        bus.irq_in = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            pulses += int'(bus.interrupt);
        end
        chk("stall_pend", int'(bus.pending_count), 1);
        bus.stall = 1'b0;
        bus.irq_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            pulses += int'(bus.interrupt);
        end
        chk("stall_dis_pulses", pulses, 0);
        bus.irq_enable = 1'b1;
        tick();
        chk("stall_release_state", int'(bus.state), 1);
        tick();
        finish_service();

        // A rise on the delivering edge leaves the count unchanged.
        bus.stall = 1'b1;
        bus.irq_in = 1'b0;
        repeat (2) tick();
        bus.irq_in = 1'b1;
        repeat (3) tick();
        bus.irq_in = 1'b0;
        repeat (2) tick();
        bus.irq_in = 1'b1;
        repeat (2) tick();
        chk("simul_pre_pend", int'(bus.pending_count), 1);
        bus.stall = 1'b0;
        tick();
        chk("simul_fire_state", int'(bus.state), 1);
        chk("simul_fire_pend", int'(bus.pending_count), 1);
        tick();
        finish_service();
        tick();
        chk("simul_second_fire", int'(bus.state), 1);
        chk("simul_second_pend", int'(bus.pending_count), 0);
        tick();
        finish_service();
        bus.rti_done = 1'b1;
        tick();
        bus.rti_done = 1'b0;
        chk("stray_rti_state", int'(bus.state), 0);
        tick();
        chk("stray_rti_state2", int'(bus.state), 0);

        // Randomized traffic against the model.
        reset = 1'b0;
        bus.irq_in = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) bus.irq_in = ~bus.irq_in;
            bus.irq_enable = ($urandom_range(0, 9) != 0);
            bus.stall      = ($urandom_range(0, 3) == 0);
            bus.rti_done   = ($urandom_range(0, 5) == 0);
            reset          = ($urandom_range(0, 199) != 0);
            tick();
            chk($sformatf("rand[%0d]", i), int'(dut_out()), int'(model_out()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Upstream front-end for the pipeline's `interrupt` input. It synchronises a raw external request line and counts request edges. It issues exactly one single-cycle `interrupt` pulse per request into the fetch/FD stage, then holds further requests off until the handler's RTI retires from write-back.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth on `irq_in`; must be at least 2.
- `HOLDOFF`, default 4: cycles spent in HOLDOFF after RTI before re-arming; 0 allowed.
- `PEND_W`, default 2: width of the pending-request counter, which saturates at 2^PEND_W−1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the `clk` rising edge.
- `irq_in`  in  1  raw asynchronous external request; a rising edge is one request.
- `irq_enable`  in  1  global enable; gates only the IDLE→FIRE transition.
- `stall`  in  1  HDU stall; while high, the block does not fire.
- `rti_done`  in  1  one-cycle pulse when an RTI completes write-back.
- `interrupt`  out  1  registered one-cycle pulse to the processor's `interrupt` input.
- `in_service`  out  1  high in FIRE and SERVICE.
- `pending_count`  out  PEND_W  number of requests not yet delivered.
- `irq_lost`  out  1  sticky; set when a request arrives while the counter is saturated.
- `state`  out  2  FSM state for debug: IDLE=00, FIRE=01, SERVICE=10, HOLDOFF=11.

## Operation
- Reset (`reset`=0 at an edge) clears to 0: sync flops, edge register, `pending_count`, `irq_lost`, holdoff counter, `state` (IDLE), `interrupt`, `in_service`.
  - Reset mid-operation drops all pending and in-service context.
- Synchroniser: chain of `SYNC_STAGES` flops. `prev` registers the last stage. `rise` = last & ~prev, combinational.
- Pending counter, per edge:
  - +1 on `rise`.
  - −1 on the IDLE→FIRE transition.
  - Both in the same edge: unchanged.
  - `rise` while saturated with no decrement: count holds and `irq_lost` is set to 1.
  - Never underflows.
- FSM:
  - IDLE: if `pending_count`≠0 & `irq_enable` & ~`stall`, go to FIRE; otherwise stay.
  - FIRE: lasts exactly one cycle with `interrupt`=1, then goes to SERVICE unconditionally.
  - SERVICE: on `rti_done`, go to HOLDOFF and load the counter with HOLDOFF−1; if `HOLDOFF`=0, go straight to IDLE instead. Otherwise stay.
  - HOLDOFF: if the counter is 0, go to IDLE; else decrement the counter.
- `rti_done` outside SERVICE is ignored.
- `irq_enable` or `stall` changing during FIRE, SERVICE or HOLDOFF has no effect.
- `interrupt` is 1 only while `state`=FIRE; it never stays high for two consecutive cycles.

## Timing
- Request latency: an `irq_in` rise sampled at edge k gives `rise` after edge k+SYNC_STAGES−1 and `pending_count`=1 after edge k+SYNC_STAGES. FIRE is entered at edge k+SYNC_STAGES+1, assuming IDLE, enabled and not stalled.
  - With defaults: 3 edges after the sampling edge.
- RTI to next fire: with `rti_done` sampled at edge e and requests pending, FIRE is entered at edge e+HOLDOFF+1, unless stalled or disabled.
- Stall or disable in IDLE delays the fire. FIRE is entered at the first edge where both are clear.
- `pending_count` is visible one edge after the causing event. `irq_lost` is visible the edge it is set.
- After reset release with `irq_in` already high: the sync flops are 0, so the level counts as one rise and the first fire follows the normal latency.

## Test plan
Defaults throughout: `SYNC_STAGES`=2, `HOLDOFF`=4, `PEND_W`=2.
- Reset: `reset`=0 for 3 edges with `irq_in`=1 → all outputs 0 and `state`=00 throughout. Release → `interrupt` high for exactly one cycle, entered on the 3rd edge after the first edge with `reset`=1; `pending_count` returns to 0.
- Single request: `irq_in` 0→1 sampled at edge 10, `rti_done` pulse at edge 20 → `interrupt`=1 only after edge 13. `in_service`=1 from edge 13 through edge 19. `state`=11 from edge 20 to edge 23, `state`=00 at edge 24.
- Burst and saturation: 4 separate rises during SERVICE → `pending_count`=3, `irq_lost`=1. `rti_done` at edge e → next FIRE at e+5 and `pending_count`=2.
- Stall/enable: pending=1 in IDLE with `stall`=1 for 6 cycles, then `irq_enable`=0 for 3 cycles → no pulse in either window. Both cleared at edge m → FIRE entered at edge m+1.
- Simultaneous events: a `rise` coincides with the IDLE→FIRE edge while pending=1 → `pending_count` stays 1 and a second FIRE follows the next RTI. A stray `rti_done` in IDLE → no state change.
- Reset in SERVICE with pending=2 → next edge: `state`=00, `pending_count`=0, `in_service`=0, and no `interrupt` pulse afterwards.
